// File: rtl/uart_autobaud.sv
`timescale 1ns/1ps
// Baud-rate trainer: measures a 0x55 sync character on rxd, derives the
// receiver prescale, holds the receiver in reset until locked, and supervises lock.
module uart_autobaud #(
    parameter int         CNT_WIDTH        = 16,
    parameter logic [9:0] DEFAULT_PRESCALE = 10'd54,
    parameter int         ERR_LIMIT        = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       retrain,
    input  logic       rx_frame_error,
    input  logic       rx_valid,
    output logic       rx_rst,
    output logic [9:0] prescale,
    output logic       locked,
    output logic       sync_error
);
    localparam int                   GW       = CNT_WIDTH - 3;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [GW-1:0]        G_ONE    = {{(GW-1){1'b0}}, 1'b1};
    localparam logic [GW-1:0]        G_ZERO   = {GW{1'b0}};
    localparam logic [CNT_WIDTH:0]   P_MAX    = (CNT_WIDTH+1)'(10'd1023);
    localparam logic [CNT_WIDTH:0]   P_ROUND  = (CNT_WIDTH+1)'(6'd32);
    localparam logic [3:0]           EC_LIMIT = 4'(ERR_LIMIT);

    typedef enum logic [2:0] {
        HUNT   = 3'd0,
        MEAS_W = 3'd1,
        MEAS_T = 3'd2,
        CHECK  = 3'd3,
        GUARD  = 3'd4,
        LOCKED = 3'd5
    } state_t;

    state_t               state_r;
    logic                 rxd_meta_r;
    logic                 rxd_sync_r;
    logic                 rxd_prev_r;
    logic [CNT_WIDTH-1:0] cnt_r;
    logic [CNT_WIDTH-1:0] w_r;
    logic [CNT_WIDTH-1:0] t8_r;
    logic [GW-1:0]        g_r;
    logic [2:0]           fe_r;
    logic                 guard_run_r;
    logic [3:0]           ec_r;

    logic                 fall_s;
    logic                 rise_s;
    logic                 cnt_max_s;
    logic [CNT_WIDTH:0]   p_full_s;
    logic [9:0]           p_s;
    logic [CNT_WIDTH+3:0] t8_ext_s;
    logic [CNT_WIDTH+3:0] w6_s;
    logic [CNT_WIDTH+3:0] w10_s;
    logic                 accept_s;
    logic [GW-1:0]        g_load_s;
    logic                 guard_cnt_s;
    logic                 err_trip_s;

    // Edge detection, prescale arithmetic and the plausibility window on the measurement
    always_comb begin
        fall_s    = rxd_prev_r & ~rxd_sync_r;
        rise_s    = ~rxd_prev_r & rxd_sync_r;
        cnt_max_s = (cnt_r == CNT_MAX);
        p_full_s  = ({1'b0, t8_r} + P_ROUND) >> 3'd6;
        if (p_full_s > P_MAX) begin
            p_s = 10'd1023;
        end else begin
            p_s = p_full_s[9:0];
        end
        t8_ext_s    = {4'd0, t8_r};
        w6_s        = ({4'd0, w_r} << 2'd2) + ({4'd0, w_r} << 2'd1);
        w10_s       = ({4'd0, w_r} << 2'd3) + ({4'd0, w_r} << 2'd1);
        accept_s    = (t8_ext_s >= w6_s) && (t8_ext_s <= w10_s) && (p_s != 10'd0);
        g_load_s    = t8_r[CNT_WIDTH-1:3];
        guard_cnt_s = (guard_run_r | rise_s) & rxd_sync_r;
        err_trip_s  = rx_frame_error & ~rx_valid & ((ec_r + 4'd1) == EC_LIMIT);
    end

    // Two-flop synchronizer plus one delay flop for edge detection, idle high
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta_r <= 1'b1;
            rxd_sync_r <= 1'b1;
            rxd_prev_r <= 1'b1;
        end else begin
            rxd_meta_r <= rxd;
            rxd_sync_r <= rxd_meta_r;
            rxd_prev_r <= rxd_sync_r;
        end
    end

    // Training / supervision state machine with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= HUNT;
            cnt_r       <= CNT_ZERO;
            w_r         <= CNT_ZERO;
            t8_r        <= CNT_ZERO;
            g_r         <= G_ZERO;
            fe_r        <= 3'd0;
            guard_run_r <= 1'b0;
            ec_r        <= 4'd0;
            rx_rst      <= 1'b1;
            prescale    <= DEFAULT_PRESCALE;
            locked      <= 1'b0;
            sync_error  <= 1'b0;
        end else begin
            sync_error <= 1'b0;
            if (retrain) begin
                state_r <= HUNT;
                rx_rst  <= 1'b1;
                locked  <= 1'b0;
                ec_r    <= 4'd0;
            end else begin
                case (state_r)
                    HUNT: begin
                        w_r         <= CNT_ZERO;
                        t8_r        <= CNT_ZERO;
                        fe_r        <= 3'd0;
                        guard_run_r <= 1'b0;
                        ec_r        <= 4'd0;
                        // The count starts at 1 so a latched value equals the edge-to-edge distance
                        if (fall_s) begin
                            cnt_r   <= CNT_ONE;
                            state_r <= MEAS_W;
                        end else begin
                            cnt_r <= CNT_ZERO;
                        end
                    end
                    MEAS_W: begin
                        if (rise_s) begin
                            w_r     <= cnt_r;
                            cnt_r   <= cnt_r + CNT_ONE;
                            state_r <= MEAS_T;
                        end else if (cnt_max_s) begin
                            sync_error <= 1'b1;
                            state_r    <= HUNT;
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end
                    MEAS_T: begin
                        if (fall_s && (fe_r == 3'd3)) begin
                            t8_r    <= cnt_r;
                            state_r <= CHECK;
                        end else if (cnt_max_s) begin
                            sync_error <= 1'b1;
                            state_r    <= HUNT;
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                            if (fall_s) begin
                                fe_r <= fe_r + 3'd1;
                            end
                        end
                    end
                    CHECK: begin
                        if (accept_s) begin
                            prescale    <= p_s;
                            g_r         <= g_load_s;
                            cnt_r       <= CNT_ONE;
                            guard_run_r <= 1'b0;
                            state_r     <= GUARD;
                        end else begin
                            sync_error <= 1'b1;
                            state_r    <= HUNT;
                        end
                    end
                    GUARD: begin
                        // Lock only after one full bit-time of uninterrupted high line
                        if (guard_run_r && (g_r == G_ZERO)) begin
                            state_r <= LOCKED;
                            rx_rst  <= 1'b0;
                            locked  <= 1'b1;
                            ec_r    <= 4'd0;
                        end else if (cnt_max_s) begin
                            sync_error <= 1'b1;
                            state_r    <= HUNT;
                        end else begin
                            cnt_r <= (rise_s | fall_s) ? CNT_ONE : (cnt_r + CNT_ONE);
                            if (rise_s) begin
                                guard_run_r <= 1'b1;
                            end
                            if (guard_cnt_s) begin
                                g_r <= g_r - G_ONE;
                            end else if (guard_run_r) begin
                                g_r <= g_load_s;
                            end
                        end
                    end
                    LOCKED: begin
                        if (err_trip_s) begin
                            state_r <= HUNT;
                            rx_rst  <= 1'b1;
                            locked  <= 1'b0;
                            ec_r    <= 4'd0;
                        end else if (rx_valid) begin
                            ec_r <= 4'd0;
                        end else if (rx_frame_error) begin
                            ec_r <= ec_r + 4'd1;
                        end
                    end
                    default: begin
                        state_r <= HUNT;
                        rx_rst  <= 1'b1;
                        locked  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_autobaud.sv
`timescale 1ns/1ps
// Self-checking bench for uart_autobaud: directed and randomized sync characters
// checked against an arithmetic model of the acceptance and prescale rules.
module tb_uart_autobaud;
    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic       retrain;
    logic       rx_frame_error;
    logic       rx_valid;
    logic       rx_rst;
    logic [9:0] prescale;
    logic       locked;
    logic       sync_error;

    int checks_cnt = 0;
    int errors_cnt = 0;
    int serr_cnt   = 0;
    int exp_prescale;

    always #5 clk = ~clk;

    uart_autobaud dut (
        .clk(clk), .rst(rst), .rxd(rxd), .retrain(retrain),
        .rx_frame_error(rx_frame_error), .rx_valid(rx_valid),
        .rx_rst(rx_rst), .prescale(prescale), .locked(locked), .sync_error(sync_error)
    );

    // Count every sync_error cycle seen on the falling edge
    always @(negedge clk) begin
        if (sync_error === 1'b1) serr_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model_p(input int t8);
        int p;
        p = (t8 + 32) / 64;
        if (p > 1023) p = 1023;
        return p;
    endfunction

    function automatic bit model_accept(input int w, input int t8);
        return (t8 >= 6 * w) && (t8 <= 10 * w) && (model_p(t8) != 0);
    endfunction

    task automatic hold(input logic lvl, input int n);
        rxd = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Start bit low for w clocks; 5th falling edge exactly t8 clocks after the 1st
    task automatic send_sync(input int w, input int t8);
        int b;
        b = (t8 - w) / 7;
        hold(1'b0, w);
        for (int i = 0; i < 6; i++) hold((i % 2 == 0) ? 1'b1 : 1'b0, b);
        hold(1'b1, t8 - w - 6 * b);
        hold(1'b0, t8 / 8);
    endtask

    task automatic run_sync(input int w, input int t8);
        int  s0;
        int  g;
        int  n;
        bit  acc;
        s0  = serr_cnt;
        acc = model_accept(w, t8);
        g   = t8 / 8;
        send_sync(w, t8);
        rxd = 1'b1;
        n   = 0;
        while (locked !== 1'b1 && n < g + 12) begin
            @(negedge clk);
            n++;
        end
        if (acc) begin
            exp_prescale = model_p(t8);
            chk("lock", locked, 1);
            chk("lock_window", (n >= g + 1 && n <= g + 8), 1);
            chk("prescale", prescale, exp_prescale);
            chk("serr_none", serr_cnt - s0, 0);
            chk("rx_rst_lock", rx_rst, 0);
        end else begin
            chk("nolock", locked, 0);
            chk("serr_one", serr_cnt - s0, 1);
            chk("prescale_keep", prescale, exp_prescale);
            chk("rx_rst_hunt", rx_rst, 1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_retrain();
        retrain = 1'b1;
        @(posedge clk);
        #1;
        retrain = 1'b0;
        @(negedge clk);
        chk("retrain_unlock", locked, 0);
        chk("retrain_rx_rst", rx_rst, 1);
        chk("retrain_prescale", prescale, exp_prescale);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rx(input logic e, input logic v);
        rx_frame_error = e;
        rx_valid       = v;
        @(posedge clk);
        #1;
        rx_frame_error = 1'b0;
        rx_valid       = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_rx_rst", rx_rst, 1);
        chk("rst_prescale", prescale, 54);
        chk("rst_locked", locked, 0);
        chk("rst_sync_error", sync_error, 0);
    endtask

    initial begin
        int s0;
        int n;
        int b;
        int w;
        rst = 1'b1; rxd = 1'b1; retrain = 1'b0; rx_frame_error = 1'b0; rx_valid = 1'b0;
        exp_prescale = 54;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk_reset_outputs();
        rst = 1'b0;
        @(posedge clk);
        #1;
        hold(1'b1, 5);

        // Slow sync, then two rates across a retrain
        run_sync(434, 3472);
        do_retrain();
        run_sync(64, 512);
        do_retrain();
        run_sync(128, 1024);
        do_retrain();

        // Corrupted sync: 5th falling edge far too late for the start-bit width
        run_sync(64, 1000);
        hold(1'b1, 20);

        // Retrain while measuring: no error pulse, next clean sync locks
        s0 = serr_cnt;
        hold(1'b0, 20); hold(1'b1, 20); hold(1'b0, 20); hold(1'b1, 20);
        do_retrain();
        run_sync(20, 160);
        chk("retrain_quiet", serr_cnt - s0, 0);
        do_retrain();

        // Frame-error supervision
        run_sync(16, 128);
        repeat (3) pulse_rx(1'b1, 1'b0);
        pulse_rx(1'b0, 1'b1);
        repeat (3) pulse_rx(1'b1, 1'b0);
        chk("err_hold_a", locked, 1);
        pulse_rx(1'b1, 1'b1);
        repeat (3) pulse_rx(1'b1, 1'b0);
        chk("err_hold_b", locked, 1);
        pulse_rx(1'b1, 1'b0);
        chk("err_unlock", locked, 0);
        chk("err_rx_rst", rx_rst, 1);
        chk("err_prescale", prescale, exp_prescale);
        @(posedge clk);
        #1;

        // Line stuck low after a start edge: measurement timeout
        s0 = serr_cnt;
        rxd = 1'b0;
        repeat (65000) @(posedge clk);
        #1;
        chk("timeout_early", serr_cnt - s0, 0);
        n = 0;
        while (serr_cnt == s0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("timeout", serr_cnt - s0, 1);
        chk("timeout_locked", locked, 0);
        chk("timeout_prescale", prescale, exp_prescale);
        hold(1'b1, 20);

        // Randomized rates and start-bit widths against the model
        for (int t = 0; t < 10; t++) begin
            b = $urandom_range(32, 8);
            w = (b * $urandom_range(170, 50)) / 100;
            if (w < 1) w = 1;
            run_sync(w, w + 7 * b);
            if (locked === 1'b1) do_retrain();
            hold(1'b1, 10);
        end

        // Synchronous reset in the middle of a measurement
        s0 = serr_cnt;
        hold(1'b0, 64); hold(1'b1, 64); hold(1'b0, 64);
        rst = 1'b1;
        rxd = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk_reset_outputs();
        rst = 1'b0;
        exp_prescale = 54;
        @(posedge clk);
        #1;
        hold(1'b1, 300);
        chk("rst_no_pulse", serr_cnt - s0, 0);
        run_sync(40, 320);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end
endmodule

// File: doc/uart_autobaud.md
# uart_autobaud

Baud-rate trainer and supervisor for the UART receive path. It measures a sync character (0x55) on the raw `rxd` line and computes the `prescale` word for the receiver. While training it holds the receiver in reset, then releases it. While locked it watches for repeated frame errors and forces a retrain when needed. It sits between the board pin and the receiver's `rst`/`prescale` inputs, and shares `rxd` with it.

## Interface
Parameters:
- CNT_WIDTH, 16, width of the interval counter; also sets the edge timeout (2^CNT_WIDTH-1 clocks).
- DEFAULT_PRESCALE, 10'd54, `prescale` value after reset and while unlocked.
- ERR_LIMIT, 4, number of consecutive frame errors that forces a retrain (range 1..15).

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- rxd  in  1  raw asynchronous serial line, idle high.
- retrain  in  1  single-cycle request to abandon lock and re-measure.
- rx_frame_error  in  1  frame_error pulse from the receiver.
- rx_valid  in  1  byte-accepted pulse from the receiver (tvalid & tready).
- rx_rst  out  1  reset to the receiver; high whenever not LOCKED.
- prescale  out  10  clocks-per-bit / 8 for the receiver.
- locked  out  1  high in LOCKED.
- sync_error  out  1  one-cycle pulse on a rejected measurement.

## Operation
- Input conditioning: `rxd` passes through a 2-flop synchronizer (reset value 1) to give `rxd_s`, plus one more flop for edge detection. All intervals are measured on `rxd_s`, so the fixed latency cancels.
- Sync character 0x55, LSB first, gives alternating levels. The 1st falling edge (start bit) and the 5th falling edge (start of bit7) are exactly 8 bit-times apart.
- States and transitions:
  - HUNT: wait for a falling edge → MEAS_W. Clear counter `cnt`, `W`, `T8`, and falling-edge count `fe`.
  - MEAS_W: `cnt` increments every cycle. On a rising edge, latch `W` = `cnt` (start-bit low width) and continue counting.
  - MEAS_T: each falling edge increments `fe`. On the 4th falling edge after the start, latch `T8` = `cnt` and → CHECK.
  - CHECK (1 cycle): compute `p` = (`T8` + 32) >> 6, clamped to 1023.
    - Accept only if `T8` >= (`W`<<2)+(`W`<<1), `T8` <= (`W`<<3)+(`W`<<1), and `p` != 0.
    - On accept: `prescale` <= `p`, load guard counter `g` <= `T8` >> 3, → GUARD.
    - On reject: pulse `sync_error` and → HUNT.
  - GUARD: on a rising edge of `rxd_s` (end of bit7), begin counting `g` down while `rxd_s` is high. If `rxd_s` goes low, reload `g`. When `g` reaches 0 → LOCKED. This holds one full bit-time of idle/stop.
  - LOCKED: `rx_rst` = 0, `locked` = 1. Error counter `ec` (4 bits) increments on `rx_frame_error`, clears on `rx_valid`. If both pulse in the same cycle, `rx_valid` wins (clear). When `ec` reaches ERR_LIMIT, or `retrain` is asserted, → HUNT with `prescale` unchanged.
- Timeout: in MEAS_W, MEAS_T or GUARD, if `cnt` (or `g` wait) reaches all-ones without the expected edge, pulse `sync_error` and → HUNT.
- `retrain` in any state other than LOCKED restarts at HUNT. No `sync_error` is pulsed in this case.
- `prescale` changes only in CHECK. It keeps the last accepted value across retrains and only returns to DEFAULT_PRESCALE on `rst`.

## Timing
- Reset values: `rx_rst`=1, `prescale`=DEFAULT_PRESCALE, `locked`=0, `sync_error`=0, state=HUNT, `ec`=0.
- Edge detection: a `rxd` transition is seen 3 clocks later. All measured intervals are exact clock counts between detected edges.
- CHECK lasts exactly 1 cycle. `prescale` updates on the clock edge leaving CHECK.
- `locked` rises and `rx_rst` falls on the same clock edge, the cycle after `g` reaches 0.
- Leaving LOCKED: `rx_rst` rises and `locked` falls on the clock edge following the triggering `retrain` or error pulse.
- `rst` in any state aborts mid-measurement with no residual pulses.

## Test plan
- Sync 0x55 at 434 clk/bit (`T8`=3472) → `prescale`=54, `locked`=1 about 1 bit-time after bit7 ends; no `sync_error`.
- Sync 0x55 at 64 clk/bit → `prescale`=8 and `locked`; then retrain at 128 clk/bit → `locked` drops on `retrain`, relocks with `prescale`=16.
- Corrupted sync: start low for 64 clocks, 5th falling edge at 1000 clocks → `sync_error` pulse, stays in HUNT, `prescale` unchanged, `rx_rst`=1.
- Start bit low then line held low for 65535+ clocks → `sync_error` pulse, return to HUNT.
- LOCKED, ERR_LIMIT=4: 3 `rx_frame_error`, 1 `rx_valid`, 3 more errors → stays locked; 4th consecutive error → `locked`=0, `rx_rst`=1 next cycle.
- `rst` asserted mid-MEAS_T → all outputs return to reset values on the next clock; the following clean sync locks normally.
